// File: rtl/crc_stream_engine.sv
// crc_stream_engine: streaming CRC-16 over DATA_W-bit beats with keep mask, abort and registered result.
// Define CRC_REFLECT_EN for reflected input bytes and reflected result.
module crc_stream_engine #(
  parameter int DATA_W = 8,
  parameter logic [15:0] POLY = 16'h1021,
  parameter logic [15:0] INIT = 16'hFFFF,
  parameter logic [15:0] XOROUT = 16'h0000
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic in_last,
  input  logic in_abort,
  output logic out_valid,
  input  logic out_ready,
  output logic [15:0] out_crc,
  output logic busy
);
  localparam int NB = DATA_W / 8;
  localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [15:0] crc, acc, fin;
  logic abort, take;
`ifdef CRC_REFLECT_EN
  function automatic logic [7:0] rin(input logic [7:0] b);
    return {<<{b}};
  endfunction
  function automatic logic [15:0] rout(input logic [15:0] c);
    return {<<{c}};
  endfunction
`else
  function automatic logic [7:0] rin(input logic [7:0] b);
    return b;
  endfunction
  function automatic logic [15:0] rout(input logic [15:0] c);
    return c;
  endfunction
`endif
  function automatic logic [15:0] fold(input logic [15:0] c0, input logic [7:0] b);
    logic [15:0] c;
    c = c0;
    for (int k = 7; k >= 0; k--) c = {c[14:0], 1'b0} ^ ((c[15] ^ b[k]) ? POLY : 16'h0000);
    return c;
  endfunction
  assign in_ready = !rst && state != DONE;
  assign busy = state != IDLE;
  assign abort = in_abort && state == ACCUM;
  assign take = in_valid && in_ready && !abort;
  // Keep is contiguous from the MSB byte, so each byte is gated by its own keep bit on the last beat.
  always_comb begin
    acc = (state == IDLE) ? INIT : crc;
    for (int i = 0; i < NB; i++)
      if (!in_last || in_keep[NB-1-i]) acc = fold(acc, rin(in_data[DATA_W-1-8*i -: 8]));
    fin = rout(acc) ^ XOROUT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      crc <= INIT;
      out_valid <= 1'b0;
      out_crc <= 16'h0000;
    end else if (abort) begin
      state <= IDLE;
      crc <= INIT;
    end else if (take) begin
      crc <= acc;
      state <= in_last ? DONE : ACCUM;
      if (in_last) begin
        out_valid <= 1'b1;
        out_crc <= fin;
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
      out_valid <= 1'b0;
    end
  end
endmodule
